ysyx_23060061_ifu_prefetch: RTL and testbench

Parametrised instruction fetch unit with an in-order prefetch queue.
- Issues sequential fetch requests (PC += 4) to the instruction memory over a valid/ready request channel and an always-accepted response channel.
- Buffers returned instructions and hands them to the IDU through a valid/ready interface.
- Handles control-flow redirects from the EXU by flushing the queue and discarding in-flight responses.

---
 rtl/ysyx_23060061_ifu_prefetch.sv | 232 +++++++++++++++++++++++
 tb/tb_ysyx_23060061_ifu_prefetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_ifu_prefetch.sv
// ysyx_23060061_ifu_prefetch
// Instruction fetch unit with an in-order prefetch queue. Sequential fetch
// requests (PC += 4) are issued against a credit budget of DEPTH entries
// (queued instructions plus in-flight requests). Returned instructions are
// buffered and presented to the IDU over a valid/ready interface. An EXU
// redirect flushes the queue and discards every in-flight response.
// Optional feature macro: IFU_PERF_CNT_EN (adds perf_fetch/perf_stall/perf_flush).
module ysyx_23060061_ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    input  logic            rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_flush
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [XLEN-1:0] r_q_data [DEPTH];
    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic            r_q_err  [DEPTH];

    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] w_fetch_pc_nxt;
    logic [XLEN-1:0] w_rsp_pc_nxt;
    logic [CW-1:0]   w_count_nxt;
    logic [CW-1:0]   w_out_nxt;
    logic [CW-1:0]   w_drop_nxt;
    logic [PW-1:0]   w_wptr_nxt;
    logic [PW-1:0]   w_rptr_nxt;

    logic [CW:0]     w_used;
    logic            w_has_credit;
    logic            w_redirect;
    logic            w_req_fire;
    logic            w_rsp;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_target;

    // Credit, handshake and redirect qualification
    always_comb begin
        w_used       = {1'b0, r_count} + {1'b0, r_outstanding};
        w_has_credit = (w_used < DEPTH_W);
        w_redirect   = redirect_valid && (r_state != S_BOOT);
        w_target     = redirect_pc & ALIGN_MASK;
        w_req_fire   = req_valid && req_ready;
        // A response without a tracked request cannot occur; ignore it rather than underflow.
        w_rsp        = rsp_valid && (r_outstanding != CNT_ZERO);
        w_push       = w_rsp && (r_state == S_RUN) && !redirect_valid;
        w_pop        = inst_valid && inst_ready;
    end

    assign req_valid  = (r_state == S_RUN) && w_has_credit && !redirect_valid;
    assign req_addr   = r_fetch_pc;
    assign inst_valid = (r_count != CNT_ZERO);
    assign inst       = r_q_data[r_rptr];
    assign inst_pc    = r_q_pc[r_rptr];
    assign inst_fault = r_q_err[r_rptr];

    // Occupancy, in-flight tracking and drop budget for the next cycle
    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_req_fire) begin
            w_out_nxt = w_out_nxt + CNT_ONE;
        end else begin
            w_out_nxt = w_out_nxt;
        end
        if (w_rsp) begin
            w_out_nxt = w_out_nxt - CNT_ONE;
        end else begin
            w_out_nxt = w_out_nxt;
        end

        if (w_redirect) begin
            w_count_nxt = CNT_ZERO;
            w_wptr_nxt  = PTR_ZERO;
            w_rptr_nxt  = PTR_ZERO;
        end else begin
            w_count_nxt = r_count + (w_push ? CNT_ONE : CNT_ZERO) - (w_pop ? CNT_ONE : CNT_ZERO);
            w_wptr_nxt  = r_wptr + (w_push ? PTR_ONE : PTR_ZERO);
            w_rptr_nxt  = r_rptr + (w_pop ? PTR_ONE : PTR_ZERO);
        end

        // Everything still in flight after this cycle is stale after a redirect.
        if (w_redirect) begin
            w_drop_nxt = w_out_nxt;
        end else if ((r_state == S_DRAIN) && w_rsp && (r_drop != CNT_ZERO)) begin
            w_drop_nxt = r_drop - CNT_ONE;
        end else begin
            w_drop_nxt = r_drop;
        end
    end

    // Fetch/response PC and state transitions
    always_comb begin
        if (redirect_valid) begin
            w_fetch_pc_nxt = w_target;
            w_rsp_pc_nxt   = w_target;
        end else begin
            w_fetch_pc_nxt = w_req_fire ? (r_fetch_pc + PC_STEP) : r_fetch_pc;
            w_rsp_pc_nxt   = w_push ? (r_rsp_pc + PC_STEP) : r_rsp_pc;
        end

        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_redirect && (w_drop_nxt != CNT_ZERO)) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (w_drop_nxt != CNT_ZERO) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_BOOT;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_count       <= CNT_ZERO;
            r_outstanding <= CNT_ZERO;
            r_drop        <= CNT_ZERO;
            r_wptr        <= PTR_ZERO;
            r_rptr        <= PTR_ZERO;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_rsp_pc      <= w_rsp_pc_nxt;
            r_count       <= w_count_nxt;
            r_outstanding <= w_out_nxt;
            r_drop        <= w_drop_nxt;
            r_wptr        <= w_wptr_nxt;
            r_rptr        <= w_rptr_nxt;
        end
    end

    // Queue storage; cleared on reset so the head outputs read zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= {XLEN{1'b0}};
                r_q_pc[i]   <= {XLEN{1'b0}};
                r_q_err[i]  <= 1'b0;
            end
        end else if (w_push) begin
            r_q_data[r_wptr] <= rsp_data;
            r_q_pc[r_wptr]   <= r_rsp_pc;
            r_q_err[r_wptr]  <= rsp_err;
        end else begin
            r_q_data[r_wptr] <= r_q_data[r_wptr];
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Free-running event counters; redirects do not clear them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_fetch <= 32'd0;
            r_perf_stall <= 32'd0;
            r_perf_flush <= 32'd0;
        end else begin
            r_perf_fetch <= r_perf_fetch + (w_req_fire ? 32'd1 : 32'd0);
            r_perf_stall <= r_perf_stall + (((r_state == S_RUN) && !w_has_credit) ? 32'd1 : 32'd0);
            r_perf_flush <= r_perf_flush + (redirect_valid ? 32'd1 : 32'd0);
        end
    end

    assign perf_fetch = r_perf_fetch;
    assign perf_stall = r_perf_stall;
    assign perf_flush = r_perf_flush;
`endif

endmodule

// File: tb/tb_ysyx_23060061_ifu_prefetch.sv
// Scoreboard testbench for ysyx_23060061_ifu_prefetch: a memory model with
// programmable latency answers accepted requests; expected instructions are
// queued as responses are driven and compared when the IDU pops them.
module tb_ysyx_23060061_ifu_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] ERR_ADDR = 32'h8000_0004;
    localparam logic [31:0] XOR_PAT  = 32'hFFFF_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    ysyx_23060061_ifu_prefetch #(
        .XLEN    (32),
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_fault    (inst_fault)
    );

    typedef struct {
        logic [31:0] addr;
        int          gen;
        int          due;
    } mem_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    mem_t mem_q[$];
    exp_t exp_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          gen = 0;
    int          lat = 1;
    int          n_pops = 0;
    int          n_fires = 0;
    logic        tb_inst_ready = 1'b1;
    logic        tb_req_ready = 1'b1;
    logic [31:0] exp_fetch_pc = RESET_PC;
    logic [31:0] exp_rsp_pc = RESET_PC;
    logic [31:0] last_req_addr = 32'h0000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check, update the model.
    task automatic step(input logic rdv, input logic [31:0] rdpc);
        mem_t m;
        exp_t e;
        logic this_rsp;
        int   rgen;
        int   stale;
        @(negedge clk);
        cyc++;
        stale = 0;
        foreach (mem_q[i]) if (mem_q[i].gen != gen) stale++;
        this_rsp = 1'b0;
        rgen = 0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            this_rsp = 1'b1;
            rgen = m.gen;
            rsp_valid = 1'b1;
            rsp_data = m.addr ^ XOR_PAT;
            rsp_err = (m.addr == ERR_ADDR);
        end else begin
            rsp_valid = 1'b0;
            rsp_data = 32'h0000_0000;
            rsp_err = 1'b0;
        end
        redirect_valid = rdv;
        redirect_pc = rdpc;
        inst_ready = tb_inst_ready;
        req_ready = tb_req_ready;
        #1;
        check_val("inst_valid", inst_valid, (exp_q.size() != 0));
        if (stale > 0) check_val("drain_no_req", req_valid, 1'b0);
        if (rdv) check_val("redirect_no_req", req_valid, 1'b0);
        if (inst_valid && inst_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("inst_pc", inst_pc, e.pc);
            check_val("inst", inst, e.data);
            check_val("inst_fault", inst_fault, e.fault);
            n_pops++;
        end
        if (this_rsp && !rdv && rgen == gen) begin
            e.pc = exp_rsp_pc;
            e.data = exp_rsp_pc ^ XOR_PAT;
            e.fault = (exp_rsp_pc == ERR_ADDR);
            exp_q.push_back(e);
            exp_rsp_pc = exp_rsp_pc + 32'd4;
        end
        if (req_valid && req_ready) begin
            check_val("req_addr", req_addr, exp_fetch_pc);
            m.addr = req_addr;
            m.gen = gen;
            m.due = cyc + lat;
            mem_q.push_back(m);
            check_val("credit", ((mem_q.size() + exp_q.size()) <= DEPTH), 1'b1);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
            last_req_addr = req_addr;
            n_fires++;
        end
        if (rdv) begin
            gen++;
            exp_q.delete();
            exp_fetch_pc = {rdpc[31:2], 2'b00};
            exp_rsp_pc = {rdpc[31:2], 2'b00};
        end
    endtask

    // Assert reset at a falling edge, check outputs immediately, release later.
    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = 32'h0000_0000;
        rsp_err = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check_val("rst_req_valid", req_valid, 1'b0);
        check_val("rst_inst_valid", inst_valid, 1'b0);
        check_val("rst_inst", inst, 32'h0000_0000);
        check_val("rst_inst_pc", inst_pc, 32'h0000_0000);
        check_val("rst_inst_fault", inst_fault, 1'b0);
        mem_q.delete();
        exp_q.delete();
        gen++;
        exp_fetch_pc = RESET_PC;
        exp_rsp_pc = RESET_PC;
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
    endtask

    // Run until the next request handshake (bounded) and check its address.
    task automatic wait_fire(input string tag, input logic [31:0] exp_addr);
        int f;
        f = n_fires;
        for (int i = 0; i < 20 && n_fires == f; i++) step(1'b0, 32'h0);
        check_val(tag, last_req_addr, exp_addr);
    endtask

    initial begin
        int p;
        int f;
        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0000_0000;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = 32'h0000_0000;
        rsp_err = 1'b0;
        inst_ready = 1'b0;

        // Sequential stream with a fault on 0x80000004, one instruction per cycle
        apply_reset(2);
        lat = 1; tb_req_ready = 1'b1; tb_inst_ready = 1'b1;
        repeat (8) step(1'b0, 32'h0);
        p = n_pops;
        repeat (10) step(1'b0, 32'h0);
        check_val("throughput", n_pops - p, 10);

        // IDU stall: credit caps issue at DEPTH, then resumes at 0x80000010
        apply_reset(2);
        tb_inst_ready = 1'b0;
        f = n_fires;
        repeat (12) step(1'b0, 32'h0);
        check_val("stall_fires", n_fires - f, DEPTH);
        check_val("stall_req_valid", req_valid, 1'b0);
        tb_inst_ready = 1'b1;
        wait_fire("resume_addr", 32'h8000_0010);
        repeat (6) step(1'b0, 32'h0);

        // Redirect with two responses outstanding
        tb_req_ready = 1'b0;
        repeat (10) step(1'b0, 32'h0);
        lat = 6; tb_req_ready = 1'b1;
        f = n_fires;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        tb_req_ready = 1'b0;
        step(1'b0, 32'h0);
        check_val("two_outstanding", n_fires - f, 2);
        step(1'b1, 32'h8000_1002);
        tb_req_ready = 1'b1;
        wait_fire("redirect_addr", 32'h8000_1000);
        lat = 1;
        repeat (12) step(1'b0, 32'h0);

        // Redirect coinciding with a response and a pop
        check_val("pre_redirect_valid", inst_valid, 1'b1);
        step(1'b1, 32'h8000_2000);
        step(1'b0, 32'h0);
        check_val("flush_inst_valid", inst_valid, 1'b0);
        repeat (8) step(1'b0, 32'h0);

        // Reset in the middle of a stream with the queue full
        tb_inst_ready = 1'b0;
        repeat (10) step(1'b0, 32'h0);
        check_val("full_before_reset", inst_valid, 1'b1);
        apply_reset(1);
        tb_inst_ready = 1'b1;
        wait_fire("post_reset_addr", RESET_PC);
        repeat (8) step(1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
